// File: rtl/nco_freq_meter_if.sv
// Measurement bus of the NCO frequency/period meter.
// The master drives control and the signal; the slave returns results.
interface nco_freq_meter_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             mode;
  logic             sig_in;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             overflow;

  modport master (
    output enable,
    output mode,
    output sig_in,
    input  count,
    input  count_valid,
    input  overflow
  );

  modport slave (
    input  enable,
    input  mode,
    input  sig_in,
    output count,
    output count_valid,
    output overflow
  );
endinterface

// File: rtl/nco_freq_meter.sv
// Frequency (edges per gate) or period (clks per cycle) meter
// for an asynchronous square wave such as a looped-back NCO MSB.
module nco_freq_meter #(
  parameter int GATE_LOG2 = 10,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  nco_freq_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FREQ,
    ARM,
    PER
  } state_e;

  localparam logic [CNT_W-1:0]     CMAX = '1;
  localparam logic [GATE_LOG2-1:0] GMAX = '1;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]     edges_q, edges_d;
  logic                 sat_q, sat_d;
  logic [CNT_W-1:0]     per_q, per_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 s1_q, s2_q, s3_q;
  logic                 rise;

  // Synchronizer and edge flop run independently of enable
  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      gate_q  <= '0;
      edges_q <= '0;
      sat_q   <= 1'b0;
      per_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      gate_q  <= gate_d;
      edges_q <= edges_d;
      sat_q   <= sat_d;
      per_q   <= per_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      s1_q    <= bus.sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    gate_d  = gate_q;
    edges_d = edges_q;
    sat_d   = sat_q;
    per_d   = per_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      gate_d  = '0;
      edges_d = '0;
      sat_d   = 1'b0;
      per_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mode_d  = bus.mode;
          gate_d  = '0;
          edges_d = '0;
          sat_d   = 1'b0;
          per_d   = '0;
          state_d = mode_d ? ARM : FREQ;
        end
        FREQ: begin
          gate_d = gate_q + 1'b1;
          if (rise) begin
            if (edges_q == CMAX) sat_d = 1'b1;
            else edges_d = edges_q + 1'b1;
          end
          // Last gate cycle: publish, next window starts clean
          if (gate_q == GMAX) begin
            count_d = edges_d;
            ovf_d   = sat_d;
            valid_d = 1'b1;
            edges_d = '0;
            sat_d   = 1'b0;
          end
        end
        ARM: begin
          if (rise) begin
            state_d = PER;
            per_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        PER: begin
          // per_q holds clks elapsed since the previous rise
          if (rise) begin
            count_d = per_q;
            ovf_d   = 1'b0;
            valid_d = 1'b1;
            per_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (per_q == CMAX) begin
            count_d = CMAX;
            ovf_d   = 1'b1;
            valid_d = 1'b1;
            per_d   = '0;
            state_d = ARM;
          end else begin
            per_d = per_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.count_valid = valid_q;

endmodule
